// File: rtl/if_id_hazard_if.sv
// Bundles the fetch-side inputs and the ID-side outputs of the IF/ID hazard block.
// The stall_cnt_o and flush_cnt_o counter signals exist only when STALL_CNT_EN is defined.
interface if_id_hazard_if #(
    parameter int ADDR_W = 32
`ifdef STALL_CNT_EN
    , parameter int CNT_W = 16
`endif
);
    logic [ADDR_W-1:0] inst_addr_i;
    logic [31:0]       inst_i;
    logic              flush_i;
    logic              idex_memread_i;
    logic [4:0]        idex_rtaddr_i;

    logic [ADDR_W-1:0] inst_addr_o;
    logic [31:0]       inst_o;
    logic              valid_o;
    logic [5:0]        opcode_o;
    logic [4:0]        rsaddr_o;
    logic [4:0]        rtaddr_o;
    logic [4:0]        rdaddr_o;
    logic [31:0]       imm_o;
    logic              stall_o;
    logic              pc_write_o;
    logic              bubble_o;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output inst_addr_i, inst_i, flush_i, idex_memread_i, idex_rtaddr_i,
        input  inst_addr_o, inst_o, valid_o, opcode_o, rsaddr_o, rtaddr_o,
               rdaddr_o, imm_o, stall_o, pc_write_o, bubble_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  inst_addr_i, inst_i, flush_i, idex_memread_i, idex_rtaddr_i,
        output inst_addr_o, inst_o, valid_o, opcode_o, rsaddr_o, rtaddr_o,
               rdaddr_o, imm_o, stall_o, pc_write_o, bubble_o,
               stall_cnt_o, flush_cnt_o
    );
`else
    modport master (
        output inst_addr_i, inst_i, flush_i, idex_memread_i, idex_rtaddr_i,
        input  inst_addr_o, inst_o, valid_o, opcode_o, rsaddr_o, rtaddr_o,
               rdaddr_o, imm_o, stall_o, pc_write_o, bubble_o
    );

    modport slave (
        input  inst_addr_i, inst_i, flush_i, idex_memread_i, idex_rtaddr_i,
        output inst_addr_o, inst_o, valid_o, opcode_o, rsaddr_o, rtaddr_o,
               rdaddr_o, imm_o, stall_o, pc_write_o, bubble_o
    );
`endif
endinterface

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use stall and branch flush for the 5-stage MIPS core.
// Defining STALL_CNT_EN adds saturating stall and flush counters.
module if_id_hazard #(
    parameter int ADDR_W = 32
`ifdef STALL_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic           clk_i,
    input  logic           rst_i,
    if_id_hazard_if.slave  bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    logic [31:0]       inst_q;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic              hazard;
    logic              stall;

    // A flushed slot is not a real instruction, so it never raises a hazard.
    // In HOLD the bubble already sits in ID/EX, so a hazard is not reported again.
    always_comb begin
        hazard = valid_q
               & bus.idex_memread_i
               & (bus.idex_rtaddr_i != 5'd0)
               & ((bus.idex_rtaddr_i == inst_q[25:21]) | (bus.idex_rtaddr_i == inst_q[20:16]));
        stall  = (state == RUN) & hazard & ~bus.flush_i;
    end

    // A flush takes priority over a stall; during a stall every register holds its value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inst_q  <= 32'd0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            state   <= RUN;
        end else if (bus.flush_i) begin
            inst_q  <= 32'd0;
            addr_q  <= bus.inst_addr_i;
            valid_q <= 1'b0;
            state   <= RUN;
        end else if (stall) begin
            state   <= HOLD;
        end else begin
            inst_q  <= bus.inst_i;
            addr_q  <= bus.inst_addr_i;
            valid_q <= 1'b1;
            state   <= RUN;
        end
    end

    assign bus.inst_o      = inst_q;
    assign bus.inst_addr_o = addr_q;
    assign bus.valid_o     = valid_q;
    assign bus.opcode_o    = inst_q[31:26];
    assign bus.rsaddr_o    = inst_q[25:21];
    assign bus.rtaddr_o    = inst_q[20:16];
    assign bus.rdaddr_o    = inst_q[15:11];
    assign bus.imm_o       = {{16{inst_q[15]}}, inst_q[15:0]};
    assign bus.stall_o     = stall;
    assign bus.pc_write_o  = ~stall;
    assign bus.bubble_o    = stall | ~valid_q;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    // Both counters stop at all-ones rather than wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (bus.flush_i && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign bus.stall_cnt_o = stall_cnt;
    assign bus.flush_cnt_o = flush_cnt;
`endif

endmodule

// File: doc/if_id_hazard.md
Name: if_id_hazard

Overview:
IF/ID pipeline register fused with load-use hazard detection and branch flush for the 5-stage MIPS core. Sits directly upstream of the ID/EX register.
- Latches the fetched instruction and its PC+4.
- Decodes register addresses, opcode and sign-extended immediate for ID/EX.
- Stalls the PC and IF/ID for one cycle on a load-use hazard against the instruction in EX, and tells control to inject a bubble into ID/EX.

Parameters:
ADDR_W, 32, width of the instruction address (PC+4) carried through.
CNT_W, 16, width of the performance counters (used only with STALL_CNT_EN).

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  asynchronous active-high reset.
inst_addr_i  in  ADDR_W  PC+4 from the fetch stage.
inst_i  in  32  fetched instruction word.
flush_i  in  1  branch/jump taken in ID; squash the instruction currently being fetched.
idex_memread_i  in  1  MemRead control bit of the instruction now in ID/EX.
idex_rtaddr_i  in  5  rt (load destination) address now in ID/EX.
inst_addr_o  out  ADDR_W  registered PC+4.
inst_o  out  32  registered instruction.
valid_o  out  1  registered instruction is real, not a flushed NOP.
opcode_o  out  6  inst[31:26].
rsaddr_o  out  5  inst[25:21].
rtaddr_o  out  5  inst[20:16].
rdaddr_o  out  5  inst[15:11].
imm_o  out  32  sign-extended inst[15:0]; bits [5:0] carry funct.
stall_o  out  1  load-use stall active this cycle.
pc_write_o  out  1  PC update enable; equals ~stall_o.
bubble_o  out  1  control zeroes ID/EX control inputs (wb/mem/ex) this cycle.
stall_cnt_o  out  CNT_W  stall-cycle count; present only with STALL_CNT_EN.
flush_cnt_o  out  CNT_W  flush count; present only with STALL_CNT_EN.

Behaviour:
- Reset (asynchronous, immediate on rst_i high):
  - inst_o=0, inst_addr_o=0, valid_o=0, FSM=RUN.
  - Therefore stall_o=0, pc_write_o=1, bubble_o=1.
  - Counters reset to 0.
  - On release, the first edge with no flush or stall loads inst_i.
- Decode outputs (opcode_o, rsaddr_o, rtaddr_o, rdaddr_o, imm_o) are combinational slices of the registered inst_o. No added latency: one cycle from inst_i to all outputs.
- hazard = valid_o & idex_memread_i & (idex_rtaddr_i != 0) & ((idex_rtaddr_i == rsaddr_o) | (idex_rtaddr_i == rtaddr_o)).
- FSM states:
  - RUN: stall_o = hazard & ~flush_i. If stall_o is high, go to HOLD; else stay in RUN.
  - HOLD: stall_o=0 (hazard masked, since ID/EX now holds the bubble). Always go to RUN, or stay RUN if flush_i.
  - HOLD lasts exactly one cycle; the block never issues two consecutive stall cycles.
- bubble_o = stall_o | ~valid_o.
- Register update per edge, priority order:
  1. flush_i: inst_o<=0, valid_o<=0, inst_addr_o<=inst_addr_i, FSM<=RUN.
  2. stall_o: all registers hold.
  3. Otherwise: load inst_i and inst_addr_i, valid_o<=1.
- Flush and hazard in the same cycle: flush wins. stall_o=0 and pc_write_o=1, so the PC takes the branch target.
- A NOP (inst 0) with valid_o=1 decodes rs=rt=0, so it never raises a hazard.

Optional Feature:
Macro STALL_CNT_EN.
- Defined: stall_cnt_o increments on each cycle with stall_o=1; flush_cnt_o increments on each cycle with flush_i=1. Both saturate at all-ones and never wrap. Both reset to 0.
- Undefined: both ports and the counter logic are absent. All other behaviour is identical.

Test Plan:
1. Assert rst_i mid-run with a valid instruction held -> immediately valid_o=0, inst_o=0, pc_write_o=1, bubble_o=1, stall_o=0.
2. Feed 0x8C080004 (lw $8,4($0)), then 0x01094020 (add $8,$8,$9) with idex_memread_i=1 and idex_rtaddr_i=8 while the add is in IF/ID -> stall_o=1 for exactly 1 cycle, add held, pc_write_o=0. Next cycle stall_o=0 even if idex_memread_i stays high.
3. idex_memread_i=1, idex_rtaddr_i=0, IF/ID holds 0x00004020 -> no stall.
4. flush_i=1 with inst_i=0x12345678 -> next cycle inst_o=0, valid_o=0, bubble_o=1, imm_o=0.
5. Hazard and flush_i together -> stall_o=0, pc_write_o=1, IF/ID squashed to NOP, FSM in RUN.
6. With STALL_CNT_EN and CNT_W=4, force 20 separated stall cycles -> stall_cnt_o saturates at 15.
